systolic_array_ws: RTL and testbench

// Parametrised NxN weight-stationary systolic matrix-vector engine, successor to the fixed 3x3 array.
// A weight matrix W is loaded row-by-row and held stationary in the PEs. Activation vectors then stream in.
// The block applies input skew and output de-skew internally, so callers see aligned vectors in and out.
// It sits between the activation buffer and the result writeback, and signals completion per stream.

---
 rtl/systolic_array_ws.sv | 267 ++++++++++++++++++++++++++
 tb/tb_systolic_array_ws.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_ws.sv
// systolic_array_ws: NxN weight-stationary systolic matrix-vector engine.
// Weights are held in the PEs; activations stream in with internal skew and
// results leave de-skewed, so callers see aligned vectors on both sides.
// Optional feature macro: ACC_SAT_EN (saturating PE adds plus sat_flag_o).
module systolic_array_ws #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            w_valid_i,
  output logic            w_ready_o,
  input  logic [N*DW-1:0] w_row_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [N*DW-1:0] in_vec_i,
  input  logic            in_last_i,
  output logic            out_valid_o,
  output logic [N*AW-1:0] out_vec_o,
  output logic            out_last_o,
  output logic            busy_o,
`ifdef ACC_SAT_EN
  output logic            sat_flag_o,
`endif
  output logic            done_o
);

  localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LAT = 2 * N;
  localparam int unsigned PW  = 2 * DW;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READY, S_STREAM, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   row_q, row_d, wr_row;
  logic            w_rdy_q, w_rdy_d, in_rdy_q, in_rdy_d, busy_q, busy_d;
  logic            w_fire, in_fire;
  logic [LAT-1:0]  vld_q, last_q;
  logic            out_valid_q, out_last_q, done_q;
  logic [N*AW-1:0] out_vec_q, col_res;

  logic signed [DW-1:0] w_q  [N][N];
  logic signed [DW-1:0] a_q  [N][N];
  logic signed [DW-1:0] a_in [N][N];
  logic signed [AW-1:0] p_q  [N][N];
  logic signed [AW-1:0] p_in [N][N];
  logic signed [AW-1:0] p_d  [N][N];
  logic [N*DW-1:0]      skew_q [N];
  logic signed [AW-1:0] ds_q [N-1][N];
`ifdef ACC_SAT_EN
  logic         s_q  [N][N];
  logic         s_in [N][N];
  logic         s_d  [N][N];
  logic [N-1:0] sds_q [N-1];
  logic [N-1:0] col_sat;
  logic         sat_flag_q;
  assign sat_flag_o = sat_flag_q;
`endif

  // An input offered in READY takes priority over a concurrent weight beat.
  assign w_ready_o   = w_rdy_q && !((state_q == S_READY) && in_valid_i);
  assign in_ready_o  = in_rdy_q;
  assign busy_o      = busy_q;
  assign out_valid_o = out_valid_q;
  assign out_vec_o   = out_vec_q;
  assign out_last_o  = out_last_q;
  assign done_o      = done_q;
  assign w_fire      = w_valid_i && w_ready_o;
  assign in_fire     = in_valid_i && in_ready_o;
  assign wr_row      = (state_q == S_LOAD) ? row_q : '0;

  // Next-state, row counter and registered handshake/busy outputs.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      S_IDLE: if (w_fire) begin
        state_d = S_LOAD;
        row_d   = CW'(1);
      end
      S_LOAD: if (w_fire) begin
        if (row_q == CW'(N - 1)) begin
          state_d = S_READY;
          row_d   = '0;
        end else begin
          row_d = row_q + CW'(1);
        end
      end
      S_READY: begin
        if (in_fire) begin
          state_d = in_last_i ? S_DRAIN : S_STREAM;
        end else if (w_fire) begin
          state_d = S_LOAD;
          row_d   = CW'(1);
        end
      end
      S_STREAM: if (in_fire && in_last_i) state_d = S_DRAIN;
      S_DRAIN:  if (done_q) state_d = S_READY;
      default:  state_d = S_IDLE;
    endcase
    w_rdy_d  = state_d inside {S_IDLE, S_LOAD, S_READY};
    in_rdy_d = state_d inside {S_READY, S_STREAM};
    busy_d   = state_d inside {S_LOAD, S_STREAM, S_DRAIN};
  end

  // FSM state and control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      w_rdy_q  <= 1'b1;
      in_rdy_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      w_rdy_q  <= w_rdy_d;
      in_rdy_q <= in_rdy_d;
      busy_q   <= busy_d;
    end
  end

  // Stationary weights: each accepted beat overwrites one row.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) w_q[i][j] <= '0;
    end else if (w_fire) begin
      for (int j = 0; j < N; j++) w_q[wr_row][j] <= w_row_i[j*DW +: DW];
    end
  end

  // Input skew line; empty slots carry zeros, valid/last ride alongside.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N; k++) skew_q[k] <= '0;
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      skew_q[0] <= in_fire ? in_vec_i : '0;
      for (int k = 1; k < N; k++) skew_q[k] <= skew_q[k-1];
      vld_q  <= {vld_q[LAT-2:0], in_fire};
      last_q <= {last_q[LAT-2:0], in_fire && in_last_i};
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [PW-1:0] prod;
      if (j == 0) begin : g_a0
        assign a_in[i][j] = skew_q[i][i*DW +: DW];
      end else begin : g_an
        assign a_in[i][j] = a_q[i][j-1];
      end
      if (i == 0) begin : g_p0
        assign p_in[i][j] = '0;
      end else begin : g_pn
        assign p_in[i][j] = p_q[i-1][j];
      end
      assign prod = PW'(a_in[i][j]) * PW'(w_q[i][j]);
`ifdef ACC_SAT_EN
      logic signed [AW:0]   sum;
      logic signed [AW-1:0] p_nx;
      logic                 hit;
      assign sum = (AW+1)'(p_in[i][j]) + (AW+1)'(prod);
      // Clamp when the two top bits of the widened sum disagree.
      always_comb begin
        hit  = (sum[AW] != sum[AW-1]);
        p_nx = sum[AW-1:0];
        if (hit) p_nx = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end
      if (i == 0) begin : g_s0
        assign s_in[i][j] = 1'b0;
      end else begin : g_sn
        assign s_in[i][j] = s_q[i-1][j];
      end
      assign p_d[i][j] = p_nx;
      assign s_d[i][j] = s_in[i][j] | hit;
`else
      assign p_d[i][j] = p_in[i][j] + AW'(prod);
`endif
    end
  end

  // PE array: activations move right, partial sums move down.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_q[i][j] <= '0;
          p_q[i][j] <= '0;
`ifdef ACC_SAT_EN
          s_q[i][j] <= 1'b0;
`endif
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_q[i][j] <= a_in[i][j];
          p_q[i][j] <= p_d[i][j];
`ifdef ACC_SAT_EN
          s_q[i][j] <= s_d[i][j];
`endif
        end
    end
  end

  // Output de-skew: column j waits N-1-j extra cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N - 1; k++) begin
        for (int j = 0; j < N; j++) ds_q[k][j] <= '0;
`ifdef ACC_SAT_EN
        sds_q[k] <= '0;
`endif
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        ds_q[0][j] <= p_q[N-1][j];
        for (int k = 1; k < N - 1; k++) ds_q[k][j] <= ds_q[k-1][j];
`ifdef ACC_SAT_EN
        sds_q[0][j] <= s_q[N-1][j];
        for (int k = 1; k < N - 1; k++) sds_q[k][j] <= sds_q[k-1][j];
`endif
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_out
    if (j == N - 1) begin : g_direct
      assign col_res[j*AW +: AW] = p_q[N-1][j];
`ifdef ACC_SAT_EN
      assign col_sat[j] = s_q[N-1][j];
`endif
    end else begin : g_delayed
      assign col_res[j*AW +: AW] = ds_q[N-2-j][j];
`ifdef ACC_SAT_EN
      assign col_sat[j] = sds_q[N-2-j][j];
`endif
    end
  end

  // Result register: vector and last hold while no result is valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef ACC_SAT_EN
      sat_flag_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= vld_q[LAT-1];
      done_q      <= vld_q[LAT-1] && last_q[LAT-1];
      if (vld_q[LAT-1]) begin
        out_vec_q  <= col_res;
        out_last_q <= last_q[LAT-1];
`ifdef ACC_SAT_EN
        sat_flag_q <= |col_sat;
`endif
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_ws.sv
// Bench for systolic_array_ws (N=3): matrix-vector model plus directed vectors.
module tb_systolic_array_ws;
  localparam int unsigned N  = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;

  logic clk, rst;
  logic w_valid, w_ready, in_valid, in_ready, in_last;
  logic out_valid, out_last, busy, done;
  logic [N*DW-1:0] w_row, in_vec;
  logic [N*AW-1:0] out_vec;
`ifdef ACC_SAT_EN
  logic sat_flag;
`endif

  systolic_array_ws #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_row_i(w_row),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_vec_i(in_vec), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_vec_o(out_vec), .out_last_o(out_last),
    .busy_o(busy),
`ifdef ACC_SAT_EN
    .sat_flag_o(sat_flag),
`endif
    .done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int Wm [N][N];
  int wrow_m = 0;

  typedef struct { logic [N*AW-1:0] y; bit last; bit sat; int due; } exp_t;
  exp_t            exp_q[$];
  logic [N*AW-1:0] cap_q[$];
  int              cap_cyc_q[$];
  int              acc_cyc_q[$];
  bit              cap_sat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkv(input string name, input logic [N*AW-1:0] act, input logic [N*AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pack3(input int a, input int b, input int c);
    logic [N*DW-1:0] v;
    v = {c[DW-1:0], b[DW-1:0], a[DW-1:0]};
    return v;
  endfunction

  function automatic logic [N*AW-1:0] vec3(input int a, input int b, input int c);
    logic [N*AW-1:0] v;
    v = {c[AW-1:0], b[AW-1:0], a[AW-1:0]};
    return v;
  endfunction

  // y[j] = sum_i x[i]*W[i][j]; each add clamps when saturation is enabled.
  function automatic logic [N*AW-1:0] model_y(input logic [N*DW-1:0] xv, output bit sat);
    logic [N*AW-1:0]      y;
    longint               acc;
    logic signed [DW-1:0] xi;
    y   = '0;
    sat = 1'b0;
    for (int j = 0; j < N; j++) begin
      acc = 0;
      for (int i = 0; i < N; i++) begin
        xi  = xv[i*DW +: DW];
        acc = acc + longint'(xi) * longint'(Wm[i][j]);
`ifdef ACC_SAT_EN
        if (acc > 64'sd2147483647) begin
          acc = 64'sd2147483647;
          sat = 1'b1;
        end else if (acc < -64'sd2147483648) begin
          acc = -64'sd2147483648;
          sat = 1'b1;
        end
`endif
      end
      y[j*AW +: AW] = acc[AW-1:0];
    end
    return y;
  endfunction

  // Compare process: outputs checked every cycle against the model's schedule.
  always @(negedge clk) begin
    exp_t e;
    bit   ev;
    bit   s;
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_output: got none expected %h due cycle %0d", e.y, e.due);
      end
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk1("out_valid", out_valid, ev);
      if (ev) begin
        e = exp_q.pop_front();
        chkv("out_vec", out_vec, e.y);
        chk1("out_last", out_last, e.last);
        chk1("done", done, e.last);
`ifdef ACC_SAT_EN
        chk1("sat_flag", sat_flag, e.sat);
`endif
      end else begin
        chk1("done_idle", done, 1'b0);
      end
      if (out_valid) begin
        cap_q.push_back(out_vec);
        cap_cyc_q.push_back(cyc);
`ifdef ACC_SAT_EN
        cap_sat_q.push_back(sat_flag);
`endif
      end
      if (done) done_cnt++;
      if (w_valid && w_ready) begin
        for (int j = 0; j < N; j++) Wm[wrow_m][j] = int'($signed(w_row[j*DW +: DW]));
        wrow_m = (wrow_m + 1) % N;
      end
      if (in_valid && in_ready) begin
        e.y    = model_y(in_vec, s);
        e.sat  = s;
        e.last = in_last;
        e.due  = cyc + 7;
        exp_q.push_back(e);
        acc_cyc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    cap_q.delete();
    cap_cyc_q.delete();
    acc_cyc_q.delete();
    cap_sat_q.delete();
  endtask

  task automatic load_w(input logic [N*DW-1:0] r0, input logic [N*DW-1:0] r1,
                        input logic [N*DW-1:0] r2);
    logic [N*DW-1:0] rows [N];
    int n;
    rows = '{r0, r1, r2};
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      n = 0;
      w_valid = 1'b1;
      w_row   = rows[k];
      @(negedge clk);
      while (!w_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!w_ready) begin
        checks++;
        failures++;
        $display("FAIL w_ready_timeout: got 0 expected 1 (row %0d)", k);
      end
      tick();
    end
    w_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [N*DW-1:0] x, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_vec   = x;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got 0 expected 1");
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; w_valid = 1'b0; w_row = '0; in_valid = 1'b0; in_vec = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_w_ready", w_ready, 1'b1);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chkv("rst_out_vec", out_vec, '0);
    chk1("rst_out_last", out_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // 1: back-to-back stream
    load_w(pack3(1, 2, 3), pack3(4, 5, 6), pack3(7, 8, 9));
    chk1("ready_in_ready", in_ready, 1'b1);
    chk1("ready_busy", busy, 1'b0);
    clear_caps();
    send_vec(pack3(1, 2, 3), 1'b0);
    send_vec(pack3(4, 5, 6), 1'b0);
    send_vec(pack3(7, 8, 9), 1'b1);
    chk1("drain_in_ready", in_ready, 1'b0);
    chk1("drain_busy", busy, 1'b1);
    wait_done();
    chki("t1_count", cap_q.size(), 3);
    chkv("t1_y0", cap_q[0], vec3(30, 36, 42));
    chkv("t1_y1", cap_q[1], vec3(66, 81, 96));
    chkv("t1_y2", cap_q[2], vec3(102, 126, 150));
    chki("t1_latency", cap_cyc_q[0] - acc_cyc_q[0], 6);
    chki("t1_spacing", cap_cyc_q[2] - cap_cyc_q[0], 2);

    // 2: bubble of two cycles after vector 1
    clear_caps();
    send_vec(pack3(1, 2, 3), 1'b0);
    idle(2);
    send_vec(pack3(4, 5, 6), 1'b0);
    send_vec(pack3(7, 8, 9), 1'b1);
    wait_done();
    chki("t2_count", cap_q.size(), 3);
    chkv("t2_y0", cap_q[0], vec3(30, 36, 42));
    chkv("t2_y1", cap_q[1], vec3(66, 81, 96));
    chkv("t2_y2", cap_q[2], vec3(102, 126, 150));
    chki("t2_gap", cap_cyc_q[1] - cap_cyc_q[0], 3);
    chki("t2_tail", cap_cyc_q[2] - cap_cyc_q[1], 1);

    // 3: single-vector stream from READY
    clear_caps();
    send_vec(pack3(1, 0, 0), 1'b1);
    wait_done();
    chkv("t3_y", cap_q[0], vec3(1, 2, 3));
    chki("t3_latency", cap_cyc_q[0] - acc_cyc_q[0], 6);
    chk1("t3_back_ready", in_ready, 1'b1);
    chk1("t3_not_busy", busy, 1'b0);

    // 4: identity reload; weight beats offered during a stream are refused
    load_w(pack3(1, 0, 0), pack3(0, 1, 0), pack3(0, 0, 1));
    clear_caps();
    w_valid = 1'b1; w_row = pack3(99, 99, 99);
    in_valid = 1'b1; in_vec = pack3(-5, 7, 9); in_last = 1'b0;
    @(negedge clk);
    chk1("t4_w_ready_ready", w_ready, 1'b0);
    tick();
    in_vec = pack3(2, 3, 4); in_last = 1'b1;
    @(negedge clk);
    chk1("t4_w_ready_stream", w_ready, 1'b0);
    tick();
    w_valid = 1'b0;
    wait_done();
    chkv("t4_y0", cap_q[0], vec3(-5, 7, 9));
    chkv("t4_y1", cap_q[1], vec3(2, 3, 4));

    // 5: reset mid-stream, then inputs refused until weights are reloaded
    load_w(pack3(1, 2, 3), pack3(4, 5, 6), pack3(7, 8, 9));
    for (int k = 0; k < 8; k++) send_vec(pack3(1, 2, 3), 1'b0);
    rst = 1'b1;
    #1;
    chk1("t5_out_valid", out_valid, 1'b0);
    chk1("t5_done", done, 1'b0);
    chk1("t5_in_ready", in_ready, 1'b0);
    chk1("t5_busy", busy, 1'b0);
    exp_q.delete();
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) Wm[i][j] = 0;
    wrow_m = 0;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_vec = pack3(1, 2, 3); in_last = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk1("t5_refused", in_ready, 1'b0);
      tick();
    end
    idle(8);
    load_w(pack3(1, 2, 3), pack3(4, 5, 6), pack3(7, 8, 9));
    clear_caps();
    send_vec(pack3(1, 2, 3), 1'b1);
    wait_done();
    chkv("t5_y", cap_q[0], vec3(30, 36, 42));

    // 6: overflow corner, all operands 32767
    load_w(pack3(32767, 32767, 32767), pack3(32767, 32767, 32767), pack3(32767, 32767, 32767));
    clear_caps();
    send_vec(pack3(32767, 32767, 32767), 1'b1);
    wait_done();
`ifdef ACC_SAT_EN
    chkv("t6_sat_y", cap_q[0], vec3(2147483647, 2147483647, 2147483647));
    chk1("t6_sat_flag", cap_sat_q[0], 1'b1);
`else
    chkv("t6_wrap_y", cap_q[0], vec3(-1073938429, -1073938429, -1073938429));
`endif
    chki("done_pulses", done_cnt, 6);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
